sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and access sequencer for the single-port
//  sram block (cs/wr/rd/addr/din/dout). Each requester posts one read or write
//  over a req/gnt/done handshake. The block serialises the accesses, generates
//  the SRAM strobe timing and returns read data per requester.
// PARAMETERS
//  AW         8  address width (sram_addr, addr0/1)
//  DW         8  data width (din/dout, wdata0/1, rdata0/1)
//  READ_WAIT  1  extra cycles sram_rd is held low before dout is sampled (>=0)
// PORTS
//  clk        in   1   system clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req0/req1  in   1   request; held high with we/addr/wdata stable until gnt
//  we0/we1    in   1   1 = write, 0 = read
//  addr0/1    in   AW  access address
//  wdata0/1   in   DW  write data
//  gnt0/gnt1  out  1   one-cycle pulse: request accepted, fields latched
//  done0/1    out  1   one-cycle pulse: access complete (rdata valid if read)
//  rdata0/1   out  DW  last read data for that requester, held until next read
//  sram_cs    out  1   chip select, active high
//  sram_wr    out  1   write strobe, active high
//  sram_rd    out  1   read enable, active low
//  sram_addr  out  AW  SRAM address
//  sram_din   out  DW  SRAM write data
//  sram_dout  in   DW  SRAM read data
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt*/done*=0, rdata*=0, sram_cs=0,
//   sram_wr=0, sram_rd=1, sram_addr=0, sram_din=0, last_winner=1.
//   An in-flight access is abandoned on reset: no done is produced.
//  FSM: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
//  IDLE: sram_cs=0. If any req is high, pick a winner at the edge; latch
//   we/addr/wdata and the winner id; go to SETUP. Requests seen outside
//   IDLE are ignored.
//  Arbitration: a single requester wins. If both request, the requester not
//   equal to last_winner wins. last_winner updates on every grant.
//  SETUP (1 cycle): gnt<winner>=1, sram_cs=1, sram_addr/sram_din driven,
//   sram_wr=0, sram_rd=1.
//  STROBE, write (1 cycle): sram_wr=1, sram_rd=1.
//  STROBE, read (READ_WAIT+1 cycles): sram_rd=0, sram_wr=0. sram_dout is
//   sampled into rdata<winner> at the last edge of STROBE.
//  DONE (1 cycle): sram_cs=1, sram_wr=0, sram_rd=1, done<winner>=1.
//  sram_addr/sram_din hold the latched values from SETUP through DONE.
//   sram_wr and sram_rd=0 are never asserted together.
//  Latency (gnt cycle = N): write done at N+2; read done at N+2+READ_WAIT.
//   At least one IDLE cycle separates accesses: a write takes 4 cycles per
//   access, a read takes 4+READ_WAIT.
//  Address is used as given. No wrap logic; addresses 0 and 2^AW-1 are legal.
//  rdata of the non-winning requester is never disturbed.
// TESTING
//  1 Reset: rst_n=0 mid-sim -> sram_cs=0, sram_wr=0, sram_rd=1, gnt*/done*=0
//    without waiting for a clock edge.
//  2 req0 write addr=0x01 data=0x01 -> gnt0 1 cycle; sram_wr high exactly 1
//    cycle with addr 0x01/din 0x01; done0 2 cycles after gnt0. Then req0 read
//    0x01 -> done0 3 cycles after gnt0 (READ_WAIT=1); rdata0=0x01.
//  3 Same cycle: req0 write 0x02<=0x04 and req1 write 0x04<=0x10 after reset
//    -> req0 served first, then req1. Read back -> 0x04 and 0x10.
//  4 Both requesters hold req for 4 accesses each -> gnt order 0,1,0,1,...;
//    no overlap of cs windows.
//  5 rst_n low during a write STROBE -> sram_wr falls at once, no done0.
//    After release, a write/read of 0x21<=0x0F completes normally.
//  6 Overwrite 0x01 with 0x61, write 0xFF<=0xF5, then read both ->
//    rdata=0x61 and rdata=0xF5. req1 rdata1 is unchanged by req0 reads.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester handshake and SRAM pin bundle for sram_arbiter.
// The slave modport is the arbiter's view; master is the requesters/SRAM side.
interface sram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          sram_cs;
  logic          sram_wr;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
           sram_cs, sram_wr, sram_rd, sram_addr, sram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
           sram_cs, sram_wr, sram_rd, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter that serialises single reads/writes onto
// a single-port SRAM and sequences its cs/wr/rd strobes.
module sram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int READ_WAIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam int            CW        = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT);

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On contention the requester that did not win last time goes first.
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (we_q || cnt_q == WAIT_LAST) begin
          state_d = DONE;
          if (!we_q) begin
            if (win_q) rdata1_d = bus.sram_dout;
            else       rdata0_d = bus.sram_dout;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign bus.gnt0      = (state_q == SETUP) && !win_q;
  assign bus.gnt1      = (state_q == SETUP) &&  win_q;
  assign bus.done0     = (state_q == DONE)  && !win_q;
  assign bus.done1     = (state_q == DONE)  &&  win_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.sram_cs   = (state_q != IDLE);
  assign bus.sram_wr   = (state_q == STROBE) &&  we_q;
  assign bus.sram_rd   = !((state_q == STROBE) && !we_q);
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: behavioural SRAM, one task per scenario,
// each with inline checks against hand-computed expectations.
module tb_sram_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  int   wr_cnt, rd_cnt, excl_viol, done0_cnt, done1_cnt;
  logic [7:0] wr_addr, wr_din;
  int   g_id[$];
  int   g_cyc[$];
  logic [7:0] mem [256];

  sram_arbiter_if #(.AW(8), .DW(8)) bus ();

  sram_arbiter #(.AW(8), .DW(8), .READ_WAIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sram_cs && bus.sram_wr) mem[bus.sram_addr] <= bus.sram_din;
  end

  assign bus.sram_dout = mem[bus.sram_addr];

  always @(negedge clk) begin
    if (bus.sram_wr) begin
      wr_cnt++;
      wr_addr = bus.sram_addr;
      wr_din  = bus.sram_din;
    end
    if (!bus.sram_rd) rd_cnt++;
    if (bus.sram_wr && !bus.sram_rd) excl_viol++;
    if (bus.gnt0 && bus.gnt1) excl_viol++;
    if (bus.done0) done0_cnt++;
    if (bus.done1) done1_cnt++;
    if (bus.gnt0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
    if (bus.gnt1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic access(input int id, input logic we, input logic [7:0] a,
                        input logic [7:0] d, output int gc, output int dc,
                        output logic [7:0] rd);
    bit got;
    gc = -1; dc = -1; rd = 8'h00;
    @(negedge clk);
    if (id == 0) begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    else         begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.gnt0 : bus.gnt1) begin
        got = 1'b1;
        gc  = cyc;
        if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gnt_timeout id=%0d addr=%02h got=none required=gnt", id, a);
      if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.done0 : bus.done1) begin
        got = 1'b1;
        dc  = cyc;
        rd  = (id == 0) ? bus.rdata0 : bus.rdata1;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout id=%0d addr=%02h got=none required=done", id, a);
    end
    $display("access id=%0d we=%0d addr=%02h wdata=%02h gnt@%0d done@%0d rdata=%02h",
             id, we, a, d, gc, dc, rd);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.sram_cs !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b required=0", bus.sram_cs); end
    checks++; if (bus.sram_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b required=0", bus.sram_wr); end
    checks++; if (bus.sram_rd !== 1'b1) begin failures++; $display("FAIL rst_rd got=%b required=1", bus.sram_rd); end
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0000) begin
      failures++; $display("FAIL rst_handshake got=%b required=0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}); end
    checks++; if ({bus.sram_addr, bus.sram_din} !== 16'h0000) begin
      failures++; $display("FAIL rst_addr_din got=%04h required=0000", {bus.sram_addr, bus.sram_din}); end
    checks++; if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
      failures++; $display("FAIL rst_rdata got=%04h required=0000", {bus.rdata0, bus.rdata1}); end
    @(negedge clk);
    rst_n = 1'b1;
    // Mid-access async reset during a read strobe.
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h55;
    @(negedge clk);
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.sram_rd !== 1'b0) begin failures++; $display("FAIL mid_rd_strobe got=%b required=0", bus.sram_rd); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.sram_cs !== 1'b0) begin failures++; $display("FAIL mid_rst_cs got=%b required=0", bus.sram_cs); end
    checks++; if (bus.sram_rd !== 1'b1) begin failures++; $display("FAIL mid_rst_rd got=%b required=1", bus.sram_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int gc, dc;
    logic [7:0] rd;
    wr_cnt = 0;
    access(0, 1'b1, 8'h01, 8'h01, gc, dc, rd);
    checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL wr_pulse_len got=%0d required=1", wr_cnt); end
    checks++; if (wr_addr !== 8'h01) begin failures++; $display("FAIL wr_addr got=%02h required=01", wr_addr); end
    checks++; if (wr_din !== 8'h01) begin failures++; $display("FAIL wr_din got=%02h required=01", wr_din); end
    checks++; if (dc - gc !== 2) begin failures++; $display("FAIL wr_latency got=%0d required=2", dc - gc); end
    rd_cnt = 0;
    access(0, 1'b0, 8'h01, 8'h00, gc, dc, rd);
    checks++; if (dc - gc !== 3) begin failures++; $display("FAIL rd_latency got=%0d required=3", dc - gc); end
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL rd_data got=%02h required=01", rd); end
    checks++; if (rd_cnt !== 2) begin failures++; $display("FAIL rd_strobe_len got=%0d required=2", rd_cnt); end
  endtask

  task automatic test_contention();
    int ga, da, gb, db;
    logic [7:0] ra, rb;
    do_reset();
    fork
      access(0, 1'b1, 8'h02, 8'h04, ga, da, ra);
      access(1, 1'b1, 8'h04, 8'h10, gb, db, rb);
    join
    checks++; if (gb - ga !== 4) begin failures++; $display("FAIL contention_order got=%0d required=4", gb - ga); end
    access(0, 1'b0, 8'h02, 8'h00, ga, da, ra);
    checks++; if (ra !== 8'h04) begin failures++; $display("FAIL readback_02 got=%02h required=04", ra); end
    access(1, 1'b0, 8'h04, 8'h00, gb, db, rb);
    checks++; if (rb !== 8'h10) begin failures++; $display("FAIL readback_04 got=%02h required=10", rb); end
  endtask

  task automatic test_back_to_back();
    g_id.delete();
    g_cyc.delete();
    fork
      begin
        int gc, dc; logic [7:0] rd;
        for (int k = 0; k < 4; k++) access(0, 1'b1, 8'h30 + 8'(k), 8'hA0 + 8'(k), gc, dc, rd);
      end
      begin
        int gc, dc; logic [7:0] rd;
        for (int k = 0; k < 4; k++) access(1, 1'b1, 8'h40 + 8'(k), 8'hB0 + 8'(k), gc, dc, rd);
      end
    join
    checks++; if (g_id.size() !== 8) begin failures++; $display("FAIL b2b_count got=%0d required=8", g_id.size()); end
    for (int i = 0; i < 8 && i < g_id.size(); i++) begin
      checks++;
      if (g_id[i] !== (i % 2)) begin failures++; $display("FAIL b2b_order idx=%0d got=%0d required=%0d", i, g_id[i], i % 2); end
      if (i > 0) begin
        checks++;
        if (g_cyc[i] - g_cyc[i-1] !== 4) begin
          failures++; $display("FAIL b2b_spacing idx=%0d got=%0d required=4", i, g_cyc[i] - g_cyc[i-1]); end
      end
    end
    checks++; if (mem[8'h33] !== 8'hA3 || mem[8'h43] !== 8'hB3) begin
      failures++; $display("FAIL b2b_data got=%02h/%02h required=A3/B3", mem[8'h33], mem[8'h43]); end
  endtask

  task automatic test_reset_in_write();
    int gc, dc, dcnt;
    logic [7:0] rd;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h21; bus.wdata0 = 8'h0F;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus.sram_wr !== 1'b1) begin failures++; $display("FAIL abort_wr_strobe got=%b required=1", bus.sram_wr); end
    dcnt = done0_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.sram_wr !== 1'b0) begin failures++; $display("FAIL abort_wr_fall got=%b required=0", bus.sram_wr); end
    checks++; if (bus.sram_cs !== 1'b0) begin failures++; $display("FAIL abort_cs got=%b required=0", bus.sram_cs); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done0_cnt !== dcnt) begin failures++; $display("FAIL abort_no_done got=%0d required=%0d", done0_cnt, dcnt); end
    access(0, 1'b1, 8'h21, 8'h0F, gc, dc, rd);
    checks++; if (dc - gc !== 2) begin failures++; $display("FAIL post_rst_wr_latency got=%0d required=2", dc - gc); end
    access(0, 1'b0, 8'h21, 8'h00, gc, dc, rd);
    checks++; if (rd !== 8'h0F) begin failures++; $display("FAIL post_rst_read got=%02h required=0F", rd); end
  endtask

  task automatic test_boundary();
    int gc, dc;
    logic [7:0] rd;
    access(1, 1'b0, 8'h04, 8'h00, gc, dc, rd);
    checks++; if (rd !== 8'h10) begin failures++; $display("FAIL rdata1_setup got=%02h required=10", rd); end
    access(0, 1'b1, 8'h01, 8'h61, gc, dc, rd);
    access(0, 1'b1, 8'hFF, 8'hF5, gc, dc, rd);
    access(0, 1'b0, 8'h01, 8'h00, gc, dc, rd);
    checks++; if (rd !== 8'h61) begin failures++; $display("FAIL overwrite_01 got=%02h required=61", rd); end
    checks++; if (bus.rdata1 !== 8'h10) begin failures++; $display("FAIL rdata1_kept_a got=%02h required=10", bus.rdata1); end
    access(0, 1'b0, 8'hFF, 8'h00, gc, dc, rd);
    checks++; if (rd !== 8'hF5) begin failures++; $display("FAIL addr_ff got=%02h required=F5", rd); end
    checks++; if (bus.rdata1 !== 8'h10) begin failures++; $display("FAIL rdata1_kept_b got=%02h required=10", bus.rdata1); end
    checks++; if (excl_viol !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d required=0", excl_viol); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    wr_cnt = 0; rd_cnt = 0; excl_viol = 0; done0_cnt = 0; done1_cnt = 0;
    wr_addr = 8'h00; wr_din = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_in_write();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end
endmodule
